// File: rtl/mac_share_ctrl.sv
// Round-robin arbiter sharing one combinational multiplier between NUM_REQ requesters,
// with a private accumulator per requester and a backpressured, id-tagged result port.
module mac_share_ctrl #(
    parameter int unsigned A_WIDTH   = 7,
    parameter int unsigned B_WIDTH   = 4,
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned ACC_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
    input  logic [NUM_REQ-1:0]           req_acc,
    output logic [A_WIDTH-1:0]           mul_a,
    output logic [B_WIDTH-1:0]           mul_b,
    input  logic [A_WIDTH+B_WIDTH-1:0]   mul_p,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [ACC_WIDTH-1:0]         res_data,
    output logic [$clog2(NUM_REQ)-1:0]   res_id,
    output logic                         busy
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {StIdle, StCompute, StResult} state_e;

    state_e               state_q, state_d;
    logic [IdW-1:0]       last_grant_q;
    logic [IdW-1:0]       grant_id;
    logic                 grant_found;
    int unsigned          idx;

    logic [A_WIDTH-1:0]   sel_a, op_a_q;
    logic [B_WIDTH-1:0]   sel_b, op_b_q;
    logic                 sel_acc, op_acc_q;
    logic [IdW-1:0]       op_id_q;

    logic [ACC_WIDTH-1:0] acc_q [NUM_REQ];
    logic [ACC_WIDTH-1:0] acc_cur, acc_new;
    logic                 res_valid_q;
    logic [ACC_WIDTH-1:0] res_data_q;
    logic [IdW-1:0]       res_id_q;

    // Search starts one past the previous winner so every holder is served within NUM_REQ ops.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(last_grant_q) + k) % NUM_REQ;
            if (!grant_found && req_valid[IdW'(idx)]) begin
                grant_found = 1'b1;
                grant_id    = IdW'(idx);
            end
        end
    end

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_acc = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IdW'(i)) begin
                sel_a   = req_a[i*A_WIDTH +: A_WIDTH];
                sel_b   = req_b[i*B_WIDTH +: B_WIDTH];
                sel_acc = req_acc[i];
            end
        end
    end

    always_comb begin
        acc_cur = op_acc_q ? acc_q[op_id_q] : '0;
        acc_new = acc_cur + ACC_WIDTH'(mul_p);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (grant_found) state_d = StCompute;
            StCompute: state_d = StResult;
            StResult:  if (res_ready) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state_q == StIdle && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
        busy      = (state_q != StIdle);
        mul_a     = op_a_q;
        mul_b     = op_b_q;
        res_valid = res_valid_q;
        res_data  = res_data_q;
        res_id    = res_id_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= IdW'(NUM_REQ - 1);
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_acc_q     <= 1'b0;
            op_id_q      <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_id_q     <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            if (state_q == StIdle && grant_found) begin
                op_a_q       <= sel_a;
                op_b_q       <= sel_b;
                op_acc_q     <= sel_acc;
                op_id_q      <= grant_id;
                last_grant_q <= grant_id;
            end
            if (state_q == StCompute) begin
                acc_q[op_id_q] <= acc_new;
                res_data_q     <= acc_new;
                res_id_q       <= op_id_q;
                res_valid_q    <= 1'b1;
            end
            if (state_q == StResult && res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_share_ctrl.sv
// Self-checking bench for mac_share_ctrl: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_mac_share_ctrl;

    localparam int AW = 7;
    localparam int BW = 4;
    localparam int N  = 4;
    localparam int CW = 16;
    localparam int PW = AW + BW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_a = '0;
    logic [N*BW-1:0] req_b = '0;
    logic [N-1:0]    req_acc = '0;
    logic [AW-1:0]   mul_a;
    logic [BW-1:0]   mul_b;
    logic [PW-1:0]   mul_p;
    logic            res_valid;
    logic            res_ready = 1'b1;
    logic [CW-1:0]   res_data;
    logic [1:0]      res_id;
    logic            busy;

    mac_share_ctrl #(
        .A_WIDTH  (AW),
        .B_WIDTH  (BW),
        .NUM_REQ  (N),
        .ACC_WIDTH(CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_acc  (req_acc),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_p    (mul_p),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_id   (res_id),
        .busy     (busy)
    );

    // Stand-in for the shared combinational multiplier.
    assign mul_p = PW'(mul_a) * PW'(mul_b);

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: one operation in flight, phase 0 = waiting, 1 = multiplying, 2 = holding.
    int m_phase, m_last, m_hs_id, m_g, m_prod;
    int m_acc[N];
    int m_a, m_b, m_opacc, m_id, m_res_data, m_res_id;

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step();
        if (!rst_n) begin
            m_phase = 0; m_last = N - 1; m_hs_id = -1;
            m_a = 0; m_b = 0; m_opacc = 0; m_id = 0; m_res_data = 0; m_res_id = 0;
            for (int i = 0; i < N; i++) m_acc[i] = 0;
        end else begin
            m_hs_id = -1;
            case (m_phase)
                0: begin
                    m_g = rr_pick(req_valid, m_last);
                    if (m_g >= 0) begin
                        m_a = int'(req_a[m_g*AW +: AW]);
                        m_b = int'(req_b[m_g*BW +: BW]);
                        m_opacc = int'(req_acc[m_g]);
                        m_id = m_g; m_last = m_g; m_hs_id = m_g; m_phase = 1;
                    end
                end
                1: begin
                    m_prod = m_a * m_b;
                    m_res_data = ((m_opacc != 0 ? m_acc[m_id] : 0) + m_prod) % 65536;
                    m_acc[m_id] = m_res_data;
                    m_res_id = m_id;
                    m_phase = 2;
                end
                default: if (res_ready) m_phase = 0;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    int           c_g;
    logic [N-1:0] c_rdy;

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            c_rdy = '0;
            if (m_phase == 0) begin
                c_g = rr_pick(req_valid, m_last);
                if (c_g >= 0) c_rdy[c_g] = 1'b1;
            end
            check("req_ready", 32'(req_ready), 32'(c_rdy));
            check("busy", 32'(busy), 32'(m_phase != 0));
            check("res_valid", 32'(res_valid), 32'(m_phase == 2));
            check("mul_a", 32'(mul_a), m_a);
            check("mul_b", 32'(mul_b), m_b);
            if (m_phase == 2) begin
                check("res_data", 32'(res_data), m_res_data);
                check("res_id", 32'(res_id), m_res_id);
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        req_valid = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic do_op(input int id, input int a, input int b, input bit acc,
                         output int data, output int rid, output int lat);
        bit got;
        @(posedge clk); #1;
        req_valid[id] = 1'b1;
        req_a[id*AW +: AW] = AW'(a);
        req_b[id*BW +: BW] = BW'(b);
        req_acc[id] = acc;
        data = -1; rid = -1; lat = -1;
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1'b1;
        end
        if (!got) begin
            check("grant_timeout", 0, 1);
            req_valid[id] = 1'b0;
            return;
        end
        @(posedge clk); #1 req_valid[id] = 1'b0;
        lat = 1;
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (res_valid) got = 1'b1;
            else lat++;
        end
        if (!got) begin
            check("result_timeout", 0, 1);
            return;
        end
        data = int'(res_data);
        rid  = int'(res_id);
    endtask

    int grant_q[$];

    task automatic run_grants(input logic [N-1:0] mask, input int n);
        bit got;
        int idx;
        grant_q.delete();
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            req_a[i*AW +: AW] = AW'(10 + i*7);
            req_b[i*BW +: BW] = BW'(i + 2);
            req_acc[i] = 1'(i % 2);
        end
        req_valid = mask;
        for (int k = 0; k < n; k++) begin
            got = 1'b0;
            idx = -1;
            for (int t = 0; t < 40 && !got; t++) begin
                @(negedge clk);
                if (req_ready != '0) got = 1'b1;
            end
            if (!got) check("fair_timeout", 0, 1);
            else begin
                for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
                grant_q.push_back(idx);
            end
            @(posedge clk); #1;
        end
        req_valid = '0;
        repeat (4) @(posedge clk);
    endtask

    int d, r, l, cnt;
    bit got;
    int exp_fair1[4] = '{0, 1, 2, 3};
    int exp_fair2[4] = '{0, 2, 0, 2};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_mul_a", 32'(mul_a), 0);
        check("rst_res_data", 32'(res_data), 0);
        check("rst_res_id", 32'(res_id), 0);

        do_op(0, 127, 15, 1'b0, d, r, l);
        check("load_data", d, 1905);
        check("load_id", r, 0);
        check("load_latency", l, 2);

        do_op(1, 3, 4, 1'b0, d, r, l); check("chain_12", d, 12);
        do_op(1, 5, 6, 1'b1, d, r, l); check("chain_42", d, 42);
        do_op(1, 2, 2, 1'b0, d, r, l); check("chain_4", d, 4);
        do_op(2, 1, 1, 1'b1, d, r, l); check("req2_untouched", d, 1);
        check("req2_id", r, 2);

        apply_reset();
        run_grants(4'b1111, 4);
        check("fair1_count", grant_q.size(), 4);
        for (int k = 0; k < grant_q.size(); k++)
            check($sformatf("fair1_grant%0d", k), grant_q[k], exp_fair1[k]);
        run_grants(4'b0101, 4);
        check("fair2_count", grant_q.size(), 4);
        for (int k = 0; k < grant_q.size(); k++)
            check($sformatf("fair2_grant%0d", k), grant_q[k], exp_fair2[k]);

        res_ready = 1'b0;
        do_op(1, 9, 9, 1'b0, d, r, l);
        check("bp_data", d, 81);
        check("bp_id", r, 1);
        @(posedge clk); #1;
        req_a[0 +: AW] = AW'(3);
        req_b[0 +: BW] = BW'(3);
        req_acc[0] = 1'b0;
        req_valid[0] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_ready_low", 32'(req_ready), 0);
            check("bp_valid_held", 32'(res_valid), 1);
            check("bp_data_held", 32'(res_data), 81);
            check("bp_id_held", 32'(res_id), 1);
        end
        @(posedge clk); #1 res_ready = 1'b1;
        cnt = 0; got = 1'b0;
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge clk);
            cnt++;
            if (req_ready[0]) got = 1'b1;
        end
        check("bp_accept_delay", cnt, 2);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge clk);
            if (res_valid) got = 1'b1;
        end
        check("bp_next_data", 32'(res_data), 9);

        do_op(3, 127, 15, 1'b0, d, r, l);
        for (int k = 0; k < 34; k++) do_op(3, 127, 15, 1'b1, d, r, l);
        check("wrap_data", d, 1139);
        check("wrap_id", r, 3);

        @(posedge clk); #1;
        req_a[0 +: AW] = AW'(5);
        req_b[0 +: BW] = BW'(5);
        req_acc[0] = 1'b1;
        req_valid[0] = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (req_ready[0]) got = 1'b1;
        end
        check("midrst_grant", 32'(got), 1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_res_valid", 32'(res_valid), 0);
        check("midrst_busy", 32'(busy), 0);
        repeat (2) begin
            @(negedge clk);
            check("midrst_no_result", 32'(res_valid), 0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        do_op(0, 2, 3, 1'b0, d, r, l); check("after_rst_load", d, 6);
        do_op(0, 1, 1, 1'b1, d, r, l); check("after_rst_acc", d, 7);

        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            if (m_hs_id >= 0) req_valid[m_hs_id] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_a[i*AW +: AW] = AW'($urandom);
                    req_b[i*BW +: BW] = BW'($urandom);
                    req_acc[i] = 1'($urandom);
                    req_valid[i] = 1'b1;
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        req_valid = '0;
        res_ready = 1'b1;
        repeat (6) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
